pulse_map_player: RTL



---
 rtl/pulse_map_player.sv | 110 +++++++++++
 1 files changed

// File: rtl/pulse_map_player.sv
// Scans a BRAM pulse map one slot at a time over port B, emits one pulse per
// nonzero word and clears that word so each pulse plays exactly once.
module pulse_map_player #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_STEP   = 4,
  parameter int SLOT_CYCLES = 100,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] bram_addr,
  input  logic [31:0] bram_rdata,
  output logic [31:0] bram_wdata,
  output logic        bram_we,
  output logic        bram_en,
  output logic        pulse_out,
  output logic        frame_done,
  output logic [31:0] frame_pulses,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RD_TICK   = TMR_W'(RD_LATENCY);
  localparam logic [31:0]      STEP      = 32'(ADDR_STEP);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CLEAR, HOLD} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx, idx_next;
  logic [TMR_W-1:0] timer;
  logic [31:0]      count;
  logic             sample, hit, slot_end, last_slot, stop_or_wrap;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    slot_end   = 1'b0;
    unique case (state)
      IDLE:  if (enable) next_state = READ;
      READ:  next_state = WAIT;
      WAIT: begin
        if (timer == RD_TICK) begin
          sample     = 1'b1;
          next_state = (bram_rdata != '0) ? CLEAR : HOLD;
        end
      end
      CLEAR: next_state = HOLD;
      HOLD: begin
        if (timer == LAST_TICK) begin
          slot_end   = 1'b1;
          next_state = enable ? READ : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign hit          = sample && (bram_rdata != '0);
  assign last_slot    = (idx == LAST_IDX);
  assign stop_or_wrap = slot_end && (last_slot || !enable);
  assign idx_next     = slot_end ? (stop_or_wrap ? '0 : idx + 1'b1) : idx;

  // The port only ever writes zeros to clear a played word.
  assign bram_wdata = '0;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      count        <= '0;
      bram_addr    <= '0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      pulse_out    <= 1'b0;
      frame_done   <= 1'b0;
      frame_pulses <= '0;
    end else begin
      state <= next_state;
      idx   <= idx_next;

      // Timer sits at 0 in IDLE, so the first READ always lands on tick 0.
      if (state == IDLE || slot_end) timer <= '0;
      else                           timer <= timer + 1'b1;

      if (stop_or_wrap)                count <= '0;
      else if (hit && (count != '1))   count <= count + 1'b1;

      frame_done <= slot_end && last_slot;
      if (slot_end && last_slot) frame_pulses <= count;

      pulse_out <= hit;
      // BRAM controls are registered from the next state; CLEAR reuses the
      // address latched for READ.
      bram_en <= (next_state == READ) || (next_state == CLEAR);
      bram_we <= (next_state == CLEAR);
      if (next_state == READ) bram_addr <= 32'(idx_next) * STEP;
    end
  end

endmodule
